// File: rtl/bayer_pkg.sv
// bayer_pkg: shared encodings and constants for bayer_demosaic_2x2.
// Build option: define BAYER_GAIN_EN to add the per-channel gain stage.
package bayer_pkg;

    // Colour at (row0,col0)(row0,col1)/(row1,col0)(row1,col1)
    localparam logic [1:0] PAT_RGGB = 2'b00;
    localparam logic [1:0] PAT_GRBG = 2'b01;
    localparam logic [1:0] PAT_GBRG = 2'b10;
    localparam logic [1:0] PAT_BGGR = 2'b11;

    localparam logic MODE_DECIM = 1'b0;
    localparam logic MODE_FULL  = 1'b1;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

`ifdef BAYER_GAIN_EN
    localparam int unsigned LATENCY = 3;
`else
    localparam int unsigned LATENCY = 2;
`endif

endpackage

// File: rtl/bayer_line_buf.sv
// bayer_line_buf: one line of raw samples, registered read-before-write.
module bayer_line_buf
    import bayer_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned LINE_W = 1280,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [LINE_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read port: capture the old contents of the addressed entry on enable
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem[addr];
        end
    end

    // Storage and read register; contents are never cleared
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bayer_demosaic_2x2.sv
// bayer_demosaic_2x2: 2x2-window Bayer to RGB, decimating or sliding-window.
// Build option: BAYER_GAIN_EN adds gain ports and one extra pipeline stage.
module bayer_demosaic_2x2
    import bayer_pkg::*;
#(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LINE_W    = 1280,
    parameter int unsigned X_W       = 11,
    parameter int unsigned GAIN_W    = 12,
    parameter int unsigned GAIN_FRAC = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [X_W-1:0]    iX_Cont,
    input  logic [X_W-1:0]    iY_Cont,
    input  logic              iMODE,
    input  logic [1:0]        iPATTERN,
`ifdef BAYER_GAIN_EN
    input  logic [GAIN_W-1:0] iGAIN_R,
    input  logic [GAIN_W-1:0] iGAIN_G,
    input  logic [GAIN_W-1:0] iGAIN_B,
`endif
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic [X_W-1:0]    oX_Cont,
    output logic [X_W-1:0]    oY_Cont
);

    localparam int unsigned AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    if (GAIN_FRAC == 0 || GAIN_FRAC >= GAIN_W || LATENCY < 2) begin : g_bad_cfg
        $error("bayer_demosaic_2x2: GAIN_FRAC must lie in 1..GAIN_W-1");
    end

    // Frame state and latched configuration
    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [1:0]  pat_q, pat_d;

    // Stage 0: window registers travelling with their coordinates
    logic [DATA_W-1:0] cur_q, cur_d, curd_q, curd_d, prvd_q, prvd_d, prv;
    logic [X_W-1:0]    ox_q, ox_d, oy_q, oy_d;
    logic [1:0]        phase_q, phase_d;
    logic              wv_q, wv_d;

    // Outputs
    logic [DATA_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [X_W-1:0]    oxo_q, oxo_d, oyo_q, oyo_d;
    logic              dval_q, dval_d;

    // Stage 1 combinational colour selection
    logic [DATA_W-1:0] r_sel, b_sel, g1_sel, g2_sel, g_avg;

    logic       sof, in_range, lb_en, mode_eff, active_eff;
    logic [1:0] pat_eff;

    assign sof      = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    assign in_range = 32'(iX_Cont) < LINE_W;
    assign lb_en    = iDVAL && in_range;

    bayer_line_buf #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .ADDR_W (AW)
    ) u_line_buf (
        .clk   (iCLK),
        .en    (lb_en),
        .addr  (iX_Cont[AW-1:0]),
        .wdata (iDATA),
        .rdata (prv)
    );

`ifdef BAYER_GAIN_EN
    localparam int unsigned PW = DATA_W + GAIN_W + 1;

    logic [GAIN_W-1:0] gr_q, gr_d, gg_q, gg_d, gb_q, gb_d;
    logic [DATA_W-1:0] red1_q, red1_d, grn1_q, grn1_d, blu1_q, blu1_d;
    logic [X_W-1:0]    ox1_q, ox1_d, oy1_q, oy1_d;
    logic              v1_q, v1_d;

    function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] c,
                                                      input logic [GAIN_W-1:0] g);
        logic [PW-1:0] scaled;
        scaled = (PW'(c) * PW'(g) + (PW'(1) << (GAIN_FRAC - 1))) >> GAIN_FRAC;
        if (scaled > PW'({DATA_W{1'b1}})) begin
            return '1;
        end
        return scaled[DATA_W-1:0];
    endfunction
`endif

    // Next state for config latch, FSM and stage 0 (frozen when iDVAL is low)
    always_comb begin
        // The SOF pixel itself already runs under the configuration it carries
        mode_eff   = sof ? iMODE : mode_q;
        pat_eff    = sof ? iPATTERN : pat_q;
        active_eff = sof || (state_q == ACTIVE);

        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        if (sof) begin
            state_d = ACTIVE;
            mode_d  = iMODE;
            pat_d   = iPATTERN;
        end

        cur_d   = cur_q;
        curd_d  = curd_q;
        prvd_d  = prvd_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        phase_d = phase_q;
        wv_d    = wv_q;
        if (iDVAL) begin
            cur_d   = iDATA;
            curd_d  = cur_q;
            prvd_d  = prv;
            ox_d    = (mode_eff == MODE_FULL) ? iX_Cont - X_W'(1) : iX_Cont >> 1;
            oy_d    = (mode_eff == MODE_FULL) ? iY_Cont - X_W'(1) : iY_Cont >> 1;
            phase_d = {iY_Cont[0] ^ pat_eff[1], iX_Cont[0] ^ pat_eff[0]};
            wv_d    = in_range && (iX_Cont != '0) && (iY_Cont != '0) && active_eff &&
                      ((mode_eff == MODE_FULL) || (iX_Cont[0] && iY_Cont[0]));
        end
`ifdef BAYER_GAIN_EN
        gr_d = sof ? iGAIN_R : gr_q;
        gg_d = sof ? iGAIN_G : gg_q;
        gb_d = sof ? iGAIN_B : gb_q;
`endif
    end

    // Stage 0 registers, FSM and configuration
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= WAIT_SOF;
            mode_q  <= MODE_DECIM;
            pat_q   <= PAT_RGGB;
            cur_q   <= '0;
            curd_q  <= '0;
            prvd_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            phase_q <= '0;
            wv_q    <= 1'b0;
`ifdef BAYER_GAIN_EN
            gr_q    <= '0;
            gg_q    <= '0;
            gb_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            cur_q   <= cur_d;
            curd_q  <= curd_d;
            prvd_q  <= prvd_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            phase_q <= phase_d;
            wv_q    <= wv_d;
`ifdef BAYER_GAIN_EN
            gr_q    <= gr_d;
            gg_q    <= gg_d;
            gb_q    <= gb_d;
`endif
        end
    end

    // Route window samples to R, B and the green pair by Bayer phase of cur
    always_comb begin
        r_sel  = cur_q;
        b_sel  = prvd_q;
        g1_sel = prv;
        g2_sel = curd_q;
        case (phase_q)
            2'b11: begin r_sel = prvd_q; b_sel = cur_q;  g1_sel = prv;    g2_sel = curd_q; end
            2'b10: begin r_sel = prv;    b_sel = curd_q; g1_sel = prvd_q; g2_sel = cur_q;  end
            2'b01: begin r_sel = curd_q; b_sel = prv;    g1_sel = prvd_q; g2_sel = cur_q;  end
            default: begin r_sel = cur_q; b_sel = prvd_q; g1_sel = prv;   g2_sel = curd_q; end
        endcase
        g_avg = DATA_W'(({1'b0, g1_sel} + {1'b0, g2_sel} + (DATA_W + 1)'(1)) >> 1);
    end

`ifdef BAYER_GAIN_EN
    // Stage 1 register ahead of the gain multiply
    always_comb begin
        red1_d = red1_q;
        grn1_d = grn1_q;
        blu1_d = blu1_q;
        ox1_d  = ox1_q;
        oy1_d  = oy1_q;
        v1_d   = v1_q;
        if (iDVAL) begin
            red1_d = r_sel;
            grn1_d = g_avg;
            blu1_d = b_sel;
            ox1_d  = ox_q;
            oy1_d  = oy_q;
            v1_d   = wv_q;
        end
    end

    // Stage 1 storage
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            red1_q <= '0;
            grn1_q <= '0;
            blu1_q <= '0;
            ox1_q  <= '0;
            oy1_q  <= '0;
            v1_q   <= 1'b0;
        end else begin
            red1_q <= red1_d;
            grn1_q <= grn1_d;
            blu1_q <= blu1_d;
            ox1_q  <= ox1_d;
            oy1_q  <= oy1_d;
            v1_q   <= v1_d;
        end
    end
`endif

    // Output load: one pulse per valid window, values held between pulses
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        oxo_d   = oxo_q;
        oyo_d   = oyo_q;
`ifdef BAYER_GAIN_EN
        dval_d = iDVAL && v1_q;
        if (dval_d) begin
            red_d   = apply_gain(red1_q, gr_q);
            green_d = apply_gain(grn1_q, gg_q);
            blue_d  = apply_gain(blu1_q, gb_q);
            oxo_d   = ox1_q;
            oyo_d   = oy1_q;
        end
`else
        dval_d = iDVAL && wv_q;
        if (dval_d) begin
            red_d   = r_sel;
            green_d = g_avg;
            blue_d  = b_sel;
            oxo_d   = ox_q;
            oyo_d   = oy_q;
        end
`endif
    end

    // Output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            oxo_q   <= '0;
            oyo_q   <= '0;
            dval_q  <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            oxo_q   <= oxo_d;
            oyo_q   <= oyo_d;
            dval_q  <= dval_d;
        end
    end

    assign oRed    = red_q;
    assign oGreen  = green_q;
    assign oBlue   = blue_q;
    assign oDVAL   = dval_q;
    assign oX_Cont = oxo_q;
    assign oY_Cont = oyo_q;

endmodule

// File: doc/bayer_demosaic_2x2.md
Name: bayer_demosaic_2x2

Overview:
- Parametrised successor to the camera pipeline's fixed 12-bit, 1280-pixel Bayer-to-RGB converter.
- Builds a 2x2 window from the live pixel stream and a one-line buffer, then emits RGB.
- Configurable: data width, line length, Bayer pattern phase, and output mode (2x2 decimation or full-resolution sliding window).
- Sits between the sensor capture/counter stage and downstream resize/framebuffer logic.

Parameters:
DATA_W, 12, bits per raw sample and per RGB output channel
LINE_W, 1280, maximum pixels per line (line-buffer depth)
X_W, 11, width of column/row coordinates
GAIN_W, 12, gain word width (only with BAYER_GAIN_EN)
GAIN_FRAC, 8, fractional bits of gain (256 = 1.0)

Ports:
iCLK  in  1  clock
iRST  in  1  reset; synchronous, active-high
iDATA  in  DATA_W  raw Bayer sample
iDVAL  in  1  iDATA / iX_Cont / iY_Cont valid this cycle
iX_Cont  in  X_W  column of iDATA
iY_Cont  in  X_W  row of iDATA
iMODE  in  1  0 = decimate (1 pixel per 2x2 block), 1 = full (sliding window)
iPATTERN  in  2  00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR (colour at row 0, col 0/1 and row 1, col 0/1)
oRed  out  DATA_W  red
oGreen  out  DATA_W  green
oBlue  out  DATA_W  blue
oDVAL  out  1  output pixel valid, one-cycle pulse per pixel
oX_Cont  out  X_W  output column
oY_Cont  out  X_W  output row

Behaviour:
- Reset: all outputs 0; FSM goes to WAIT_SOF; latched mode/pattern cleared to 0. Line-buffer contents are not cleared.
- Config latch: iMODE/iPATTERN are sampled only on an accepted pixel with iX_Cont = 0 and iY_Cont = 0 (SOF). Mid-frame changes are ignored until the next SOF.
- FSM:
  - WAIT_SOF -> ACTIVE on an accepted SOF pixel. That SOF pixel is processed.
  - ACTIVE stays until reset.
  - In WAIT_SOF, pixels are written to the line buffer but oDVAL stays 0.
- Stage 0, on iDVAL only (iDVAL gaps freeze the pipeline and produce no output):
  - Line buffer reads address iX_Cont (read-before-write), then writes iDATA.
  - cur <= iDATA; curd <= previous cur; prv <= buffer read; prvd <= previous prv.
  - x, y and the window-valid flag travel with the data.
- Window valid requires: x >= 1, y >= 1, FSM ACTIVE, and mode condition:
  - decimate: x[0] = 1 and y[0] = 1;
  - full: always.
- Phase p = {y[0]^PAT[1], x[0]^PAT[0]} for the bottom-right pixel (cur):
  - p=11: R = prvd, B = cur, G pair = prv, curd
  - p=10: R = prv, B = curd, G pair = prvd, cur
  - p=01: R = curd, B = prv, G pair = prvd, cur
  - p=00: R = cur, B = prvd, G pair = prv, curd
- Green = (g1 + g2 + 1) >> 1, computed at DATA_W+1 bits, rounded (not truncated). Max input gives max output; no overflow.
- Output coordinates: decimate oX = x>>1, oY = y>>1; full oX = x-1, oY = y-1.
- Latency: oDVAL and outputs are registered exactly 2 cycles after the iDVAL cycle carrying the bottom-right pixel, assuming no iDVAL gap in stage 0's own cycle. RGB and coordinates hold between pulses.
- Boundaries:
  - Row 0 and column 0 never produce output.
  - iX_Cont >= LINE_W is out of range: no write, no output.
  - Reset asserted mid-frame: oDVAL is 0 in the following cycle and stays 0 until the next SOF.

Optional Feature:
- Macro BAYER_GAIN_EN adds ports iGAIN_R, iGAIN_G, iGAIN_B (GAIN_W, unsigned, GAIN_FRAC fractional bits) and one pipeline stage (latency 3).
- Each channel = (chan * gain + 2^(GAIN_FRAC-1)) >> GAIN_FRAC, saturated to 2^DATA_W - 1.
- Gains are latched at SOF with mode/pattern.
- Without the macro: no gain ports, latency 2, RGB passed unscaled.

Decomposition:
- Package bayer_pkg: pattern encodings (PAT_RGGB/GRBG/GBRG/BGGR), mode constants (MODE_DECIM/MODE_FULL), FSM state type, latency constant per build.
- Sub-module bayer_line_buf: single-port-behaviour RAM, LINE_W x DATA_W, registered read-before-write on enable.

Test Plan:
- RGGB, decimate, 4x4 frame, sample = 16*y + x: (1,1) -> R=0, G=(1+16+1)>>1=9, B=17, oX=0, oY=0. 4 outputs total, each 2 cycles after input.
- Same frame, full mode: 9 outputs. Window at (1,2) (p=10) -> R=2, B=17, G=(1+18+1)>>1=10.
- BGGR, decimate, all samples 4095 -> R=G=B=4095, no overflow. Green g1=4094, g2=4095 -> 4095 (rounding).
- iDVAL toggled 1-0-1 every cycle across a line: identical RGB/coordinate results to a gap-free run, no extra oDVAL.
- iRST pulsed at row 2 mid-frame: oDVAL 0 next cycle, no output for the rest of the frame, normal output after the next SOF. iMODE flipped mid-frame takes effect only at the next frame.
- BAYER_GAIN_EN, iGAIN_R = 512 (2.0), R sample 3000 -> oRed = 4095 (saturated); iGAIN_B = 128 with B = 101 -> 51.
